// File: rtl/rr_gnt_pkg.sv
// Shared types, default parameters and the round-robin search for rr_gnt_arbiter.
package rr_gnt_pkg;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_GNT_DLY  = 2;
    localparam int DEF_MAX_WAIT = 64;
    localparam int MAX_N_REQ    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    // First set bit of req searching upward from last+1, wrapping at n.
    // Walking downward lets the closest candidate overwrite the farther ones.
    function automatic int rr_pick(input logic [MAX_N_REQ-1:0] req, input int last, input int n);
        int pick;
        int idx;
        pick = last;
        for (int k = n; k >= 1; k--) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_gnt_wdog.sv
// Per-requester wait counter: counts cycles spent requesting without a grant,
// saturates at MAX_WAIT and raises a sticky timeout flag when it gets there.
module rr_gnt_wdog import rr_gnt_pkg::*; #(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic timeout
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          timeout_reg;

    always_comb begin
        cnt_next = '0;
        if (req && !gnt) begin
            cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (cnt_next == CNT_MAX) timeout_reg <= 1'b1;
        end
    end

    assign timeout = timeout_reg;

endmodule

// File: rtl/rr_gnt_arbiter.sv
// Round-robin arbiter: pick in IDLE, wait GNT_DLY cycles in DELAY, pulse gnt in GRANT,
// with a per-requester starvation watchdog.
module rr_gnt_arbiter import rr_gnt_pkg::*; #(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int GNT_DLY  = DEF_GNT_DLY,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic [N_REQ-1:0]         timeout
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [7:0] DLY_INIT = 8'(GNT_DLY);

    state_t               state_reg;
    logic [7:0]           dly_reg;
    logic [IDW-1:0]       win_reg;
    logic [IDW-1:0]       last_reg;
    logic [N_REQ-1:0]     gnt_reg;
    logic                 busy_reg;
    logic [MAX_N_REQ-1:0] req_ext;
    logic [IDW-1:0]       pick_id;

    assign req_ext = MAX_N_REQ'(req);
    assign pick_id = IDW'(rr_pick(req_ext, int'(last_reg), N_REQ));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            dly_reg   <= '0;
            win_reg   <= '0;
            last_reg  <= IDW'(N_REQ - 1);
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            gnt_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        win_reg  <= pick_id;
                        dly_reg  <= DLY_INIT;
                        busy_reg <= 1'b1;
                        if (GNT_DLY == 0) begin
                            state_reg <= ST_GRANT;
                            gnt_reg   <= N_REQ'(1) << pick_id;
                        end else begin
                            state_reg <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    dly_reg <= dly_reg - 8'd1;
                    // A winner that withdraws forfeits its turn; priority is not advanced.
                    if (!req[win_reg]) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (dly_reg == 8'd1) begin
                        state_reg <= ST_GRANT;
                        gnt_reg   <= N_REQ'(1) << win_reg;
                    end
                end
                ST_GRANT: begin
                    last_reg  <= win_reg;
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wdog
        rr_gnt_wdog #(
            .MAX_WAIT(MAX_WAIT)
        ) u_wdog (
            .clk    (clk),
            .reset  (reset),
            .req    (req[gi]),
            .gnt    (gnt_reg[gi]),
            .timeout(timeout[gi])
        );
    end

    assign gnt    = gnt_reg;
    assign gnt_id = win_reg;
    assign busy   = busy_reg;

endmodule
